x_sequencer: RTL
================

X_SEQUENCER -- requirements
Module: x_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: bit width of one data word and of the address bus.
REQ-002 Parameter NUM, default 53: number of words in one input vector x_t.
REQ-003 Parameter TIMESTEP, default 7: number of timesteps in one sample.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 start  input  1: one-cycle request to begin sequencing a sample; sampled only in IDLE.
REQ-007 sample  input  1: sample select (0 or 1), latched on accepted start.
REQ-008 reverse  input  1: direction, 0 = t ascending, 1 = t descending (BPTT); latched on accepted start.
REQ-009 abort  input  1: terminate the current sequence.
REQ-010 addr  output  WIDTH: base word address to the input-vector memory.
REQ-011 mem_data  input  NUM*WIDTH: vector read from the memory at addr, combinational (same-cycle) read.
REQ-012 x_out  output  NUM*WIDTH, signed: registered x_t presented to the LSTM cell.
REQ-013 x_valid  output  1: x_out holds a valid vector.
REQ-014 x_ready  input  1: consumer accepts x_out when x_valid and x_ready are both high.
REQ-015 t_idx  output  WIDTH: timestep index of x_out.
REQ-016 x_last  output  1: high with x_valid when x_out is the final timestep of the sequence.
REQ-017 busy  output  1: high in every state except IDLE.
REQ-018 done  output  1: one-cycle pulse after the last vector is accepted.

Function
REQ-019 The block SHALL implement four states: IDLE, FETCH, PRESENT, DONE.
REQ-020 IDLE: on start=1, latch sample and reverse, load t = reverse ? TIMESTEP-1 : 0, go to FETCH.
REQ-021 Start asserted in any state other than IDLE SHALL be ignored.
REQ-022 addr SHALL equal (sample*TIMESTEP + t)*NUM, driven from registered state, and SHALL be 0 in IDLE.
REQ-023 FETCH (one cycle): capture mem_data into x_out, t into t_idx, set x_valid=1, set x_last if t is the terminal index (TIMESTEP-1 ascending, 0 descending), go to PRESENT.
REQ-024 PRESENT: hold x_out, t_idx, x_valid and x_last stable until x_valid and x_ready are both high.
REQ-025 On handshake with x_last=0: clear x_valid, step t by +1 (ascending) or -1 (descending), go to FETCH.
REQ-026 On handshake with x_last=1: clear x_valid and x_last, go to DONE.
REQ-027 DONE: assert done for exactly one cycle, go to IDLE.
REQ-028 Latency: start accepted at cycle N gives addr valid at N+1 and x_valid=1 at N+2; steady-state throughput is one vector per 2 cycles with x_ready held high.
REQ-029 abort=1 in any state SHALL force IDLE on the next edge with x_valid=0, x_last=0 and busy=0, and SHALL NOT pulse done; abort takes priority over start and handshake in the same cycle.
REQ-030 The counter t SHALL never leave the range 0..TIMESTEP-1; no wrap-around occurs.
REQ-031 Address arithmetic SHALL be unsigned at WIDTH bits; the maximum value (2*TIMESTEP-1)*NUM SHALL fit in WIDTH.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, t=0, addr=0, x_out=0, t_idx=0, x_valid=0, x_last=0, busy=0, done=0, and latched sample/reverse=0.
REQ-033 rst SHALL override abort, start and handshake; a sequence interrupted by reset SHALL NOT resume.

Structure
REQ-034 State encodings and the default WIDTH/NUM/TIMESTEP values SHALL reside in the shared LSTM package.
REQ-035 A sub-module timestep_counter (up/down, load, terminal flag) is natural; all other logic stays in x_sequencer.

Verification
REQ-036 sample=0, reverse=0, x_ready=1 held: addr sequence 0,53,106,...,318; 7 vectors; x_last on t_idx=6; done one cycle after the 7th handshake.
REQ-037 sample=1, reverse=1: addr sequence 689,636,...,371; t_idx 6 down to 0; x_last on t_idx=0.
REQ-038 x_ready low for 5 cycles on t_idx=2: x_out, t_idx and x_valid stay stable; no addr advance; sequence then completes normally.
REQ-039 abort in PRESENT at t_idx=3: next cycle busy=0 and x_valid=0, no done pulse; a new start then begins at t=0.
REQ-040 start pulsed while busy: ignored, with sample/reverse unchanged and the sequence unchanged.
REQ-041 rst asserted mid-sequence: all outputs reach their reset values on the next edge, and x_valid stays 0 until a new start.

Source files
------------

// File: rtl/x_sequencer_pkg.sv
// Shared LSTM definitions: default dimensions and the input sequencer state encoding.
package x_sequencer_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NUM      = 53;
    localparam int DEF_TIMESTEP = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/x_sequencer_timestep_counter.sv
// Up/down timestep counter with parallel load and a direction-aware terminal flag.
module timestep_counter
    import x_sequencer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TIMESTEP = DEF_TIMESTEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_step,
    input  logic             i_down,
    output logic [WIDTH-1:0] o_t,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_t;

    // Terminal index depends on direction; stepping saturates there so t never wraps.
    assign o_terminal = i_down ? (r_t == {WIDTH{1'b0}}) : (r_t == WIDTH'(TIMESTEP - 1));
    assign o_t        = r_t;

    // Counter register: load wins over step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_t <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_t <= i_load_val;
        end else if (i_step && !o_terminal) begin
            r_t <= i_down ? (r_t - WIDTH'(1)) : (r_t + WIDTH'(1));
        end else begin
            r_t <= r_t;
        end
    end

endmodule

// File: rtl/x_sequencer.sv
// Streams the TIMESTEP input vectors of one sample from memory to the LSTM cell,
// forward or reversed, with a valid/ready handshake on each vector.
module x_sequencer
    import x_sequencer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM      = DEF_NUM,
    parameter int TIMESTEP = DEF_TIMESTEP
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        sample,
    input  logic                        reverse,
    input  logic                        abort,
    output logic [WIDTH-1:0]            addr,
    input  logic [NUM*WIDTH-1:0]        mem_data,
    output logic signed [NUM*WIDTH-1:0] x_out,
    output logic                        x_valid,
    input  logic                        x_ready,
    output logic [WIDTH-1:0]            t_idx,
    output logic                        x_last,
    output logic                        busy,
    output logic                        done
);

    seq_state_t              r_state;
    seq_state_t              w_state_nx;
    logic                    r_sample;
    logic                    r_reverse;
    logic [NUM*WIDTH-1:0]    r_x_out;
    logic [WIDTH-1:0]        r_t_idx;
    logic                    r_x_valid;
    logic                    r_x_last;
    logic [WIDTH-1:0]        w_t;
    logic                    w_terminal;
    logic                    w_handshake;
    logic                    w_load;
    logic                    w_step;
    logic [WIDTH-1:0]        w_load_val;
    logic [WIDTH-1:0]        w_addr_calc;

    assign w_handshake = r_x_valid & x_ready;
    assign w_load      = (r_state == ST_IDLE) & start & ~abort;
    assign w_step      = (r_state == ST_PRESENT) & w_handshake & ~r_x_last & ~abort;
    assign w_load_val  = reverse ? WIDTH'(TIMESTEP - 1) : {WIDTH{1'b0}};
    assign w_addr_calc = (WIDTH'(r_sample) * WIDTH'(TIMESTEP) + w_t) * WIDTH'(NUM);

    timestep_counter #(
        .WIDTH    (WIDTH),
        .TIMESTEP (TIMESTEP)
    ) u_tcnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_step     (w_step),
        .i_down     (r_reverse),
        .o_t        (w_t),
        .o_terminal (w_terminal)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        w_state_nx = r_state;
        if (abort) begin
            w_state_nx = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_nx = start ? ST_FETCH : ST_IDLE;
                ST_FETCH:   w_state_nx = ST_PRESENT;
                ST_PRESENT: begin
                    if (w_handshake) begin
                        w_state_nx = r_x_last ? ST_DONE : ST_FETCH;
                    end else begin
                        w_state_nx = ST_PRESENT;
                    end
                end
                ST_DONE:    w_state_nx = ST_IDLE;
                default:    w_state_nx = ST_IDLE;
            endcase
        end
    end

    // Sequence configuration latched only when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample  <= 1'b0;
            r_reverse <= 1'b0;
        end else if (w_load) begin
            r_sample  <= sample;
            r_reverse <= reverse;
        end else begin
            r_sample  <= r_sample;
            r_reverse <= r_reverse;
        end
    end

    // Output vector register: captured in FETCH, held through PRESENT until handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_out   <= {(NUM*WIDTH){1'b0}};
            r_t_idx   <= {WIDTH{1'b0}};
            r_x_valid <= 1'b0;
            r_x_last  <= 1'b0;
        end else if (abort) begin
            r_x_valid <= 1'b0;
            r_x_last  <= 1'b0;
        end else if (r_state == ST_FETCH) begin
            r_x_out   <= mem_data;
            r_t_idx   <= w_t;
            r_x_valid <= 1'b1;
            r_x_last  <= w_terminal;
        end else if ((r_state == ST_PRESENT) && w_handshake) begin
            r_x_valid <= 1'b0;
            r_x_last  <= 1'b0;
        end else begin
            r_x_valid <= r_x_valid;
            r_x_last  <= r_x_last;
        end
    end

    // Output decode from registered state.
    always_comb begin
        busy = (r_state != ST_IDLE);
        done = (r_state == ST_DONE);
        if (r_state == ST_IDLE) begin
            addr = {WIDTH{1'b0}};
        end else begin
            addr = w_addr_calc;
        end
    end

    assign x_out   = r_x_out;
    assign t_idx   = r_t_idx;
    assign x_valid = r_x_valid;
    assign x_last  = r_x_last;

endmodule
